// File: rtl/counter_run_controller_if.sv
// Counter/display-side bundle of the run controller: count controls out,
// live counter value in, display value and FSM state out.
interface counter_run_controller_if;
  logic [3:0] cntr;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic       wrap;
  logic [3:0] disp_val;
  logic [1:0] state;

  modport master (
    input  cntr,
    output cnt_en, cnt_up, cnt_clr, wrap, disp_val, state
  );

  modport slave (
    output cntr,
    input  cnt_en, cnt_up, cnt_clr, wrap, disp_val, state
  );
endinterface

// File: rtl/counter_run_controller.sv
// Run/pause/hold/clear sequencer for the 4-bit counter and display path:
// button conditioning, tick qualification, direction and terminal policy.
module counter_run_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          STOP_AT_END     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic btn_hold,
  input  logic switch,
  input  logic tick,
  counter_run_controller_if.master cr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Channel order: 0 start_stop, 1 clear, 2 hold, 3 switch
  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    stb;
  logic [2:0]    stb_d;
  logic [2:0]    prs;
  logic [CW-1:0] dbc [4];

  assign raw = {switch, btn_hold, btn_clear, btn_start_stop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      stb   <= '0;
      stb_d <= '0;
      prs   <= '0;
      for (int i = 0; i < 4; i++) dbc[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      stb_d <= stb[2:0];
      prs   <= stb[2:0] & ~stb_d;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != stb[i]) begin
          if (dbc[i] == LAST) begin
            stb[i] <= s2[i];
            dbc[i] <= '0;
          end else begin
            dbc[i] <= dbc[i] + 1'b1;
          end
        end else begin
          dbc[i] <= '0;
        end
      end
    end
  end

  logic       p_ss;
  logic       p_clr;
  logic       p_hold;
  logic [1:0] state_q;
  logic [1:0] state_n;
  logic       up_q;
  logic [3:0] frz_q;
  logic [3:0] frz_n;
  logic       en_q;
  logic       en_n;
  logic       clr_q;
  logic       clr_n;
  logic       wrap_q;
  logic       wrap_n;
  logic [3:0] disp_q;
  logic [3:0] term;
  logic       counting;

  assign p_ss   = prs[0];
  assign p_clr  = prs[1];
  assign p_hold = prs[2];
  assign term   = up_q ? 4'hF : 4'h0;

  always_comb begin
    state_n  = state_q;
    frz_n    = frz_q;
    clr_n    = 1'b0;
    en_n     = 1'b0;
    wrap_n   = 1'b0;
    counting = 1'b0;
    if (p_clr) begin
      state_n = IDLE;
      clr_n   = 1'b1;
      frz_n   = 4'h0;
    end else begin
      case (state_q)
        IDLE:  if (p_ss) state_n = RUN;
        PAUSE: if (p_ss) state_n = RUN;
        RUN: begin
          if (p_ss) begin
            state_n = PAUSE;
          end else if (p_hold) begin
            state_n = HOLD;
            frz_n   = cr.cntr;
          end else begin
            counting = tick;
          end
        end
        HOLD: begin
          if (p_ss)        state_n = PAUSE;
          else if (p_hold) state_n = RUN;
          else             counting = tick;
        end
        default: state_n = IDLE;
      endcase
    end
    // At the terminal count, either wrap with a flagged enable or stop
    if (counting) begin
      if (cr.cntr != term) begin
        en_n = 1'b1;
      end else if (!STOP_AT_END) begin
        en_n   = 1'b1;
        wrap_n = 1'b1;
      end else begin
        state_n = PAUSE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      up_q    <= 1'b1;
      frz_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      wrap_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_n;
      frz_q   <= frz_n;
      en_q    <= en_n;
      clr_q   <= clr_n;
      wrap_q  <= wrap_n;
      disp_q  <= (state_n == HOLD) ? frz_n : cr.cntr;
      if (state_q == IDLE || state_q == PAUSE) up_q <= stb[3];
    end
  end

  assign cr.state    = state_q;
  assign cr.cnt_up   = up_q;
  assign cr.cnt_en   = en_q;
  assign cr.cnt_clr  = clr_q;
  assign cr.wrap     = wrap_q;
  assign cr.disp_val = disp_q;

endmodule

// File: doc/counter_run_controller.md
# counter_run_controller

Run/pause/hold/clear sequencer for the 4-bit counter-and-display datapath on the lab board. Debounces three push-buttons, qualifies the 10 Hz count tick into a counter enable, and owns count direction and the terminal-count policy. Supplies the value that feeds the binary-to-BCD converter, either live or frozen. Sits between the clock dividers and the binary counter, and between the counter and the display path.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive synchronized cycles a button level must hold before it is accepted (10 ms at 100 MHz).
- STOP_AT_END, 0: 1 = stop at terminal count; 0 = wrap around.
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start_stop  in  1  raw push-button, asynchronous.
- btn_clear  in  1  raw push-button, asynchronous.
- btn_hold  in  1  raw push-button, asynchronous (display freeze).
- switch  in  1  direction level, asynchronous: 1 = up, 0 = down.
- tick  in  1  one-clk pulse at 10 Hz, synchronous to clk.
- cntr  in  4  current counter value.
- cnt_en  out  1  one-cycle count enable.
- cnt_up  out  1  direction to the counter.
- cnt_clr  out  1  one-cycle synchronous clear.
- disp_val  out  4  value sent to the display path.
- wrap  out  1  one-cycle pulse issued with a wrapping cnt_en.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, HOLD=3.

## Operation
- Each raw input passes through a 2-FF synchronizer, then a debouncer.
- Debouncer: a stable level updates after sync output differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle resets the debounce count.
- Each button yields a one-cycle press pulse on the stable 0->1 edge only.
- switch is synchronized and debounced the same way, with no edge detection.
- FSM transitions; press pulses are evaluated in the same cycle, and clear has top priority:
  - clear press in any state -> IDLE, cnt_clr=1 for 1 cycle, frozen value <- 0.
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE. hold -> HOLD, with frozen value <- cntr.
  - HOLD: hold -> RUN. start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - Presses not listed above are ignored.
  - start_stop and hold pressed in the same cycle: start_stop wins.
- cnt_up loads the debounced switch only in IDLE or PAUSE. It is held constant in RUN and HOLD, so direction never reverses mid-run.
- Counting applies in RUN or HOLD when tick=1 and no transition out of the counting states happens that cycle. The terminal count T is 15 when cnt_up=1 and 0 when cnt_up=0.
  - cntr != T: cnt_en=1.
  - cntr == T, STOP_AT_END=0: cnt_en=1 and wrap=1.
  - cntr == T, STOP_AT_END=1: cnt_en=0, next state PAUSE.
- A tick in the same cycle as any press that causes a transition is dropped: no cnt_en.
- disp_val = frozen value in HOLD, otherwise cntr (registered).

## Timing
- All outputs are registered and reflect the decision made in the previous cycle.
- cnt_en and wrap rise 1 cycle after the qualifying tick. cnt_clr rises 1 cycle after the clear press pulse.
- Press pulse latency: raw input first sampled high at edge N -> press pulse registered at edge N+2+DEBOUNCE_CYCLES. FSM effect (state, cnt_clr) is visible 1 cycle later.
- disp_val follows cntr with 1-cycle latency. On entry to HOLD it holds the cntr sampled in the hold-press cycle.
- Reset values (asserted asynchronously, released synchronously to clk):
  - state=IDLE, cnt_en=0, cnt_clr=0, wrap=0, cnt_up=1, disp_val=0.
  - Synchronizers, debouncers, stable levels and frozen value all cleared.
- Reset mid-run drops any pending enable; no cnt_en is issued after reset releases until a new start_stop press.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse. A held button produces exactly one pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then btn_start_stop high from edge 10 -> press pulse at edge 16; state=RUN at 17. Ticks then give cnt_en one cycle after each tick, with cnt_up=1.
- RUN, STOP_AT_END=0, cntr=15, tick -> cnt_en=1 and wrap=1 next cycle. With STOP_AT_END=1 -> cnt_en=0, state=PAUSE.
- RUN with cntr=7, hold press -> state=HOLD, disp_val stays 7 while cntr advances to 9. Second hold press -> disp_val tracks cntr.
- Clear press coincident with tick in RUN -> cnt_clr=1, cnt_en=0, state=IDLE. With cnt_up=0 and cntr=0 in RUN, STOP_AT_END=1 -> PAUSE on the next tick.
- btn_start_stop toggles every 2 cycles for 20 cycles, then held high -> exactly one press pulse. Toggling switch during RUN leaves cnt_up unchanged until PAUSE.
- rst_n low during RUN mid-debounce -> all outputs at reset values immediately. No cnt_en after release despite ticks.
